expansion_mailbox: RTL and testbench

EXPANSION_MAILBOX -- requirements
Module: expansion_mailbox

---
 rtl/expansion_mailbox.sv | 187 ++++++++++++++++++
 tb/tb_expansion_mailbox.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/expansion_mailbox.sv
// Z80 expansion-port mailbox at &FBD0-&FBD3: 16-byte TX/RX FIFOs between the CPU and a host byte stream.
// Optional feature macro MAILBOX_IRQ_EN enables the port 2 control register and the irq output.

module mailbox_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    logic [7:0] mem [16];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [4:0] count;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count == 5'd16);
    assign empty   = (count == 5'd0);
    // A push on a full FIFO is accepted only when a pop frees the slot in the same clk.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            count  <= 5'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 4'd1;
            if (pop_ok)  rd_ptr <= rd_ptr + 4'd1;
            count <= count + {4'd0, push_ok} - {4'd0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

module expansion_mailbox (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        m1,
    output logic [7:0]  cpu_din,
    output logic        irq,
    output logic [7:0]  host_tx_data,
    output logic        host_tx_valid,
    input  logic        host_tx_ready,
    input  logic [7:0]  host_rx_data,
    input  logic        host_rx_valid,
    output logic        host_rx_ready
);
    logic       sel;
    logic       acc;
    logic       wr_seen;
    logic       rd_held;
    logic [1:0] rd_port;
    logic       rd_pop_ok;
    logic       blocked;
    logic       tx_ovf;
    logic       wr_fire;
    logic       rd_fire;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_drop;
    logic       rx_push;
    logic       rx_pop;
    logic [7:0] tx_head;
    logic [7:0] rx_head;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] ctrl_rd;
    logic [7:0] rdata;

    assign sel = iorq & ~m1 & (cpu_addr[15:8] == 8'hFB) & (cpu_addr[7:2] == 6'b110100);
    assign acc = sel & (rd | wr);

    // blocked holds off an access that was in progress when reset arrived until its strobe drops.
    assign wr_fire = sel & wr & ~wr_seen & ~blocked;
    assign rd_fire = rd_held & ~(sel & rd);

    assign tx_push = wr_fire & (cpu_addr[1:0] == 2'd0);
    assign tx_pop  = host_tx_valid & host_tx_ready;
    assign tx_drop = tx_push & tx_full & ~tx_pop;
    assign rx_push = host_rx_valid & host_rx_ready;
    assign rx_pop  = rd_fire & (rd_port == 2'd0) & rd_pop_ok;

    assign host_tx_valid = ~tx_empty;
    assign host_tx_data  = tx_empty ? 8'h00 : tx_head;
    assign host_rx_ready = ~rx_full;

    mailbox_fifo u_tx (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (cpu_dout),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    mailbox_fifo u_rx (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (host_rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_seen   <= 1'b0;
            rd_held   <= 1'b0;
            rd_port   <= 2'd0;
            rd_pop_ok <= 1'b0;
            blocked   <= acc;
            tx_ovf    <= 1'b0;
        end else begin
            wr_seen <= sel & wr;
            rd_held <= sel & rd & ~blocked;
            blocked <= blocked & acc;
            if (sel & rd) begin
                rd_port   <= cpu_addr[1:0];
                rd_pop_ok <= ~rx_empty;
            end
            if (tx_drop)
                tx_ovf <= 1'b1;
            else if (wr_fire && cpu_addr[1:0] == 2'd1)
                tx_ovf <= 1'b0;
        end
    end

`ifdef MAILBOX_IRQ_EN
    logic rx_ie;
    logic tx_empty_ie;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ie       <= 1'b0;
            tx_empty_ie <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_fire && cpu_addr[1:0] == 2'd2) begin
                rx_ie       <= cpu_dout[0];
                tx_empty_ie <= cpu_dout[1];
            end
            irq_q <= (rx_ie & ~rx_empty) | (tx_empty_ie & tx_empty);
        end
    end

    assign ctrl_rd = {6'b0, tx_empty_ie, rx_ie};
    assign irq     = irq_q;
`else
    assign ctrl_rd = 8'h00;
    assign irq     = 1'b0;
`endif

    always_comb begin
        rdata = 8'hFF;
        case (cpu_addr[1:0])
            2'd0:    rdata = rx_empty ? 8'h00 : rx_head;
            2'd1:    rdata = {3'b000, tx_ovf, tx_full, tx_empty, rx_full, ~rx_empty};
            2'd2:    rdata = ctrl_rd;
            default: rdata = 8'hFF;
        endcase
    end

    // The board ANDs every read source, so idle must be all ones.
    assign cpu_din = (sel & rd) ? rdata : 8'hFF;
endmodule

// File: tb/tb_expansion_mailbox.sv
// Directed bench for expansion_mailbox: CPU port accesses, host streams, FIFO boundaries, reset abort.

module tb_expansion_mailbox;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        iorq = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        m1 = 1'b0;
    logic [7:0]  cpu_din;
    logic        irq;
    logic [7:0]  host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready = 1'b0;
    logic [7:0]  host_rx_data = 8'h00;
    logic        host_rx_valid = 1'b0;
    logic        host_rx_ready;

    int errors = 0;
    int checks = 0;

    expansion_mailbox dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_dout      (cpu_dout),
        .iorq          (iorq),
        .rd            (rd),
        .wr            (wr),
        .m1            (m1),
        .cpu_din       (cpu_din),
        .irq           (irq),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        cpu_addr = addr;
        cpu_dout = data;
        iorq = 1'b1;
        wr = 1'b1;
        @(negedge clk);
        iorq = 1'b0;
        wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] addr, input int hold, output logic [7:0] data);
        @(negedge clk);
        cpu_addr = addr;
        iorq = 1'b1;
        rd = 1'b1;
        #1 data = cpu_din;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        iorq = 1'b0;
        rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_push(input logic [7:0] data);
        @(negedge clk);
        host_rx_data = data;
        host_rx_valid = 1'b1;
        @(negedge clk);
        host_rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] d;

        // Reset state
        do_reset();
        #1;
        check("rst_cpu_din", cpu_din, 8'hFF);
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_tx_valid", {7'd0, host_tx_valid}, 8'h00);
        check("rst_rx_ready", {7'd0, host_rx_ready}, 8'h01);
        check("rst_tx_data", host_tx_data, 8'h00);
        cpu_read(16'hFBD1, 1, d);
        check("rst_status", d, 8'h04);

        // Single CPU write reaches host side
        cpu_write(16'hFBD0, 8'h41);
        #1;
        check("wr_tx_valid", {7'd0, host_tx_valid}, 8'h01);
        check("wr_tx_data", host_tx_data, 8'h41);
        cpu_read(16'hFBD1, 1, d);
        check("wr_status", d, 8'h00);

        // Fill to 16, overflow on 17th, clear via port 1
        do_reset();
        for (int i = 0; i < 17; i++) cpu_write(16'hFBD0, 8'h10 + 8'(i));
        cpu_read(16'hFBD1, 1, d);
        check("ovf_status", d, 8'h18);
        #1;
        check("ovf_head", host_tx_data, 8'h10);
        cpu_write(16'hFBD1, 8'h5C);
        cpu_read(16'hFBD1, 1, d);
        check("ovf_cleared", d, 8'h08);

        // Push and pop on full TX in one clk: count unchanged, no overflow
        @(negedge clk);
        cpu_addr = 16'hFBD0;
        cpu_dout = 8'hEE;
        iorq = 1'b1;
        wr = 1'b1;
        host_tx_ready = 1'b1;
        @(negedge clk);
        iorq = 1'b0;
        wr = 1'b0;
        host_tx_ready = 1'b0;
        cpu_read(16'hFBD1, 1, d);
        check("simul_status", d, 8'h08);
        @(negedge clk);
        host_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1 check($sformatf("drain_%0d", i), host_tx_data, (i < 15) ? 8'h11 + 8'(i) : 8'hEE);
            @(negedge clk);
        end
        host_tx_ready = 1'b0;
        #1;
        check("drain_valid", {7'd0, host_tx_valid}, 8'h00);
        check("drain_data", host_tx_data, 8'h00);

        // Host to CPU ordering and empty read
        do_reset();
        host_push(8'h5A);
        host_push(8'hA5);
        cpu_read(16'hFBD1, 1, d);
        check("rx_status2", d, 8'h05);
        cpu_read(16'hFBD0, 1, d);
        check("rx_read1", d, 8'h5A);
        cpu_read(16'hFBD0, 1, d);
        check("rx_read2", d, 8'hA5);
        cpu_read(16'hFBD0, 1, d);
        check("rx_read_empty", d, 8'h00);
        cpu_read(16'hFBD1, 1, d);
        check("rx_status_empty", d, 8'h04);

        // Long strobe pops once; non-selected reads float high
        do_reset();
        host_push(8'h11);
        host_push(8'h22);
        cpu_read(16'hFBD0, 12, d);
        check("long_read", d, 8'h11);
        #1;
        check("idle_din", cpu_din, 8'hFF);
        cpu_read(16'hFBD0, 1, d);
        check("long_next", d, 8'h22);
        cpu_read(16'hFBD1, 1, d);
        check("long_status", d, 8'h04);
        cpu_read(16'hFBD4, 1, d);
        check("addr_fbd4", d, 8'hFF);
        cpu_read(16'hFAD0, 1, d);
        check("addr_fad0", d, 8'hFF);
        cpu_read(16'hFBD3, 1, d);
        check("port3", d, 8'hFF);
        host_push(8'h33);
        @(negedge clk);
        m1 = 1'b1;
        cpu_read(16'hFBD0, 1, d);
        m1 = 1'b0;
        check("iack_din", d, 8'hFF);
        cpu_read(16'hFBD0, 1, d);
        check("iack_no_pop", d, 8'h33);

        // Reset during a held read aborts it
        do_reset();
        host_push(8'hC1);
        host_push(8'hC2);
        host_push(8'hC3);
        @(negedge clk);
        cpu_addr = 16'hFBD0;
        iorq = 1'b1;
        rd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("abort_din", cpu_din, 8'h00);
        check("abort_rx_ready", {7'd0, host_rx_ready}, 8'h01);
        host_rx_data = 8'h77;
        host_rx_valid = 1'b1;
        @(negedge clk);
        host_rx_valid = 1'b0;
        @(negedge clk);
        iorq = 1'b0;
        rd = 1'b0;
        repeat (2) @(negedge clk);
        cpu_read(16'hFBD1, 1, d);
        check("abort_status", d, 8'h05);
        cpu_read(16'hFBD0, 1, d);
        check("abort_byte", d, 8'h77);

        // Interrupt path
        do_reset();
`ifdef MAILBOX_IRQ_EN
        cpu_write(16'hFBD2, 8'h01);
        cpu_read(16'hFBD2, 1, d);
        check("ctrl_readback", d, 8'h01);
        host_push(8'h99);
        #1 check("irq_latency0", {7'd0, irq}, 8'h00);
        @(negedge clk);
        #1 check("irq_set", {7'd0, irq}, 8'h01);
        cpu_read(16'hFBD0, 1, d);
        check("irq_byte", d, 8'h99);
        @(negedge clk);
        #1 check("irq_clear", {7'd0, irq}, 8'h00);
`else
        cpu_write(16'hFBD2, 8'h03);
        host_push(8'h99);
        repeat (2) @(negedge clk);
        #1 check("irq_off", {7'd0, irq}, 8'h00);
        cpu_read(16'hFBD2, 1, d);
        check("ctrl_absent", d, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
